// File: rtl/vga_scan_render_module.sv
// VGA 640x480@60 scan generator with registered colour output for the
// snake pixel classifier; also produces the game-over blink signal.
module vga_scan_render_module #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int FLASH_FRAMES = 15
) (
    input  logic       Clk_50mhz,
    input  logic       Rst,
    input  logic [1:0] Object,
    input  logic [5:0] Apple_x,
    input  logic [5:0] Apple_y,
    input  logic [2:0] Game_status,
    output logic [9:0] Pixel_x,
    output logic [9:0] Pixel_y,
    output logic       Hsync,
    output logic       Vsync,
    output logic [2:0] Rgb,
    output logic       Flash_sig,
    output logic       Frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

    localparam int             FW      = $clog2(FLASH_FRAMES + 1);
    localparam logic [FW-1:0]  FC_LAST = FW'(FLASH_FRAMES - 1);

    localparam logic [1:0] OBJ_NONE = 2'b00;
    localparam logic [1:0] OBJ_HEAD = 2'b01;
    localparam logic [1:0] OBJ_BODY = 2'b10;
    localparam logic [1:0] OBJ_WALL = 2'b11;
    localparam logic [2:0] ST_END   = 3'b100;

    logic          pix_en;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [FW-1:0] frame_cnt;
    logic          h_last;
    logic          v_last;
    logic          frame_wrap;
    logic          game_end;
    logic          in_hsync;
    logic          in_vsync;
    logic          visible;
    logic          apple_hit;
    logic [2:0]    colour;

    assign Pixel_x    = h_cnt;
    assign Pixel_y    = v_cnt;
    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign frame_wrap = pix_en && h_last && v_last;
    assign game_end   = (Game_status == ST_END);
    assign in_hsync   = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign in_vsync   = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    assign visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign apple_hit  = (h_cnt[9:4] == Apple_x) && (v_cnt[9:4] == Apple_y);

    // Priority: blanking, wall, head, body, apple (snake hides the apple)
    always_comb begin
        colour = 3'b000;
        if (!visible) begin
            colour = 3'b000;
        end else if (Object == OBJ_WALL) begin
            colour = game_end ? 3'b100 : 3'b001;
        end else if (Object == OBJ_HEAD) begin
            colour = 3'b010;
        end else if (Object == OBJ_BODY) begin
            colour = 3'b011;
        end else if (Object == OBJ_NONE && apple_hit) begin
            colour = 3'b100;
        end
    end

    always_ff @(posedge Clk_50mhz or posedge Rst) begin
        if (Rst) begin
            pix_en <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
            Hsync  <= 1'b1;
            Vsync  <= 1'b1;
            Rgb    <= 3'b000;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                h_cnt <= h_last ? '0 : h_cnt + 10'd1;
                if (h_last) begin
                    v_cnt <= v_last ? '0 : v_cnt + 10'd1;
                end
                Hsync <= ~in_hsync;
                Vsync <= ~in_vsync;
                Rgb   <= colour;
            end
        end
    end

    // Blink only counts frames while the game is over
    always_ff @(posedge Clk_50mhz or posedge Rst) begin
        if (Rst) begin
            Frame_start <= 1'b0;
            Flash_sig   <= 1'b1;
            frame_cnt   <= '0;
        end else begin
            Frame_start <= frame_wrap;
            if (!game_end) begin
                frame_cnt <= '0;
                Flash_sig <= 1'b1;
            end else if (frame_wrap) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt <= '0;
                    Flash_sig <= ~Flash_sig;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_render_module.sv
// Bench: a shrunken-geometry instance for full frames and blink, plus a
// default-geometry instance for real line timing, against a pixel-index model.
module tb_vga_scan_render_module;

    localparam int SHA = 40, SHFP = 4, SHS = 8, SHBP = 4;
    localparam int SVA = 30, SVFP = 2, SVS = 2, SVBP = 2;
    localparam int SFF = 2;
    localparam int SF  = (SHA + SHFP + SHS + SHBP) * (SVA + SVFP + SVS + SVBP);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
        logic       fl;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] obj;
    logic [5:0] ax = '0;
    logic [5:0] ay = '0;
    logic [2:0] st = 3'b010;
    int         mode = 0;
    int         seed = 0;
    int         k = 0;
    int         passed = 0;
    int         fails = 0;
    int         total = 0;

    logic [9:0] s_px, s_py, f_px, f_py;
    logic       s_hs, s_vs, s_fl, s_fs, f_hs, f_vs, f_fl, f_fs;
    logic [2:0] s_rgb, f_rgb;

    always #10 clk = ~clk;

    function automatic logic [1:0] objf(int md, int x, int y, int sd);
        if (md == 0) return 2'b11;
        if (md == 1) return (x >= 20 && x < 24 && y >= 18 && y < 20) ? 2'b01 : 2'b00;
        return 2'(((x * 5 + y * 3 + sd) / 7) % 4);
    endfunction

    function automatic logic [2:0] colour(int x, int y, int ha, int va,
                                          logic [1:0] o, logic [5:0] axv,
                                          logic [5:0] ayv, logic [2:0] stv);
        if (x >= ha || y >= va) return 3'b000;
        if (o == 2'b11) return (stv == 3'b100) ? 3'b100 : 3'b001;
        if (o == 2'b01) return 3'b010;
        if (o == 2'b10) return 3'b011;
        if (x / 16 == int'(axv) && y / 16 == int'(ayv)) return 3'b100;
        return 3'b000;
    endfunction

    // Expected outputs after the k-th clock edge since reset release
    function automatic exp_t model(int kk, int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp, int ff,
                                   int md, int sd, logic [5:0] axv,
                                   logic [5:0] ayv, logic [2:0] stv);
        exp_t e;
        int ht, vt, f, c, p, px, py;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        f  = ht * vt;
        c  = kk / 2;
        e.x   = 10'((c % f) % ht);
        e.y   = 10'((c % f) / ht);
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.rgb = 3'b000;
        e.fs  = 1'b0;
        if (c > 0) begin
            p  = (c - 1) % f;
            px = p % ht;
            py = p / ht;
            e.hs  = !(px >= ha + hfp && px < ha + hfp + hsw);
            e.vs  = !(py >= va + vfp && py < va + vfp + vsw);
            e.rgb = colour(px, py, ha, va, objf(md, px, py, sd), axv, ayv, stv);
            e.fs  = (kk % 2 == 0) && (c % f == 0);
        end
        e.fl = (stv == 3'b100) ? (((c / f) / ff) % 2 == 0) : 1'b1;
        return e;
    endfunction

    always_comb obj = objf(mode, int'(s_px), int'(s_py), seed);

    vga_scan_render_module #(
        .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
        .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP),
        .FLASH_FRAMES(SFF)
    ) u_small (
        .Clk_50mhz(clk), .Rst(rst), .Object(obj),
        .Apple_x(ax), .Apple_y(ay), .Game_status(st),
        .Pixel_x(s_px), .Pixel_y(s_py), .Hsync(s_hs), .Vsync(s_vs),
        .Rgb(s_rgb), .Flash_sig(s_fl), .Frame_start(s_fs)
    );

    vga_scan_render_module u_full (
        .Clk_50mhz(clk), .Rst(rst), .Object(2'b11),
        .Apple_x(6'd0), .Apple_y(6'd0), .Game_status(3'b010),
        .Pixel_x(f_px), .Pixel_y(f_py), .Hsync(f_hs), .Vsync(f_vs),
        .Rgb(f_rgb), .Flash_sig(f_fl), .Frame_start(f_fs)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        exp_t g;
        e = model(k, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP, SFF,
                  mode, seed, ax, ay, st);
        g = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 15,
                  0, 0, 6'd0, 6'd0, 3'b010);
        chk("s_px", 32'(s_px), 32'(e.x));
        chk("s_py", 32'(s_py), 32'(e.y));
        chk("s_hs", 32'(s_hs), 32'(e.hs));
        chk("s_vs", 32'(s_vs), 32'(e.vs));
        chk("s_rgb", 32'(s_rgb), 32'(e.rgb));
        chk("s_flash", 32'(s_fl), 32'(e.fl));
        chk("s_fstart", 32'(s_fs), 32'(e.fs));
        chk("f_px", 32'(f_px), 32'(g.x));
        chk("f_py", 32'(f_py), 32'(g.y));
        chk("f_hs", 32'(f_hs), 32'(g.hs));
        chk("f_vs", 32'(f_vs), 32'(g.vs));
        chk("f_rgb", 32'(f_rgb), 32'(g.rgb));
        chk("f_flash", 32'(f_fl), 32'(g.fl));
        chk("f_fstart", 32'(f_fs), 32'(g.fs));
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk);
            k++;
            #5;
            check_all();
        end
    endtask

    // Asserted between edges: outputs must clear before any clock edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        k = 0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        mode = 0; st = 3'b010; ax = 6'd0; ay = 6'd0;
        do_reset();
        run(2 * 2 * SF + 10);

        mode = 1; st = 3'b001; ax = 6'd1; ay = 6'd1;
        do_reset();
        run(2 * SF + 8);

        repeat (2) begin
            mode = 2;
            seed = int'($urandom_range(0, 1000));
            ax   = 6'($urandom_range(0, 3));
            ay   = 6'($urandom_range(0, 2));
            st   = 3'($urandom_range(0, 7));
            do_reset();
            run(2 * SF + 8);
        end

        mode = 0; st = 3'b100; ax = 6'd0; ay = 6'd0;
        do_reset();
        run(12 * SF + 200);
        chk("flash_low_in_end", 32'(s_fl), 32'd0);
        st = 3'b010;
        @(posedge clk);
        #5;
        chk("flash_restore", 32'(s_fl), 32'd1);

        mode = 0; st = 3'b010;
        do_reset();
        run(601);
        do_reset();
        run(400);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
